apb_master: RTL and testbench

- APB requester that turns a simple valid/ready command port into APB transfers to the two peripherals, slave1 and slave2.
- Drives PSEL1/PSEL2, PENABLE, PWRITE, PADDR and PWDATA; returns read data or write completion on a one-cycle response strobe.
- Sits between the system-side controller and the APB slaves; it is the initiator counterpart of the existing slave blocks.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_slave_mux.sv | 19 +
 rtl/apb_master.sv | 199 +++++++++++++++++++
 tb/tb_apb_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared constants for the APB requester: FSM state encoding and default bus geometry.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_SEL_BIT = 7;

endpackage

// File: rtl/apb_slave_mux.sv
// Picks the ready and read data of whichever slave is currently addressed.
module apb_slave_mux
  import apb_pkg::*;
#(
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              sel2,
  input  logic              pready1,
  input  logic              pready2,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2,
  output logic              pready,
  output logic [DATA_W-1:0] prdata
);

  assign pready = sel2 ? pready2 : pready1;
  assign prdata = sel2 ? prdata2 : prdata1;

endmodule

// File: rtl/apb_master.sv
// APB requester: converts valid/ready commands into SETUP/ACCESS transfers to two slaves.
// Optional macro APB_TIMEOUT_EN aborts transfers stuck in ACCESS for TIMEOUT cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int SEL_BIT = APB_SEL_BIT
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  logic [1:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel1_q, psel1_d;
  logic              psel2_q, psel2_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // The latched address, not the live command, decides which slave is listened to.
  apb_slave_mux #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel2    (paddr_q[SEL_BIT]),
    .pready1 (PREADY1),
    .pready2 (PREADY2),
    .prdata1 (PRDATA1),
    .prdata2 (PRDATA2),
    .pready  (sel_ready),
    .prdata  (sel_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        psel1_d     = 1'b0;
        psel2_d     = 1'b0;
        penable_d   = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          psel1_d     = ~cmd_addr[SEL_BIT];
          psel2_d     = cmd_addr[SEL_BIT];
          cmd_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) begin
            rsp_rdata_d = sel_rdata;
          end
          state_d = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        // Give up on a slave that never answers; read data is left untouched.
        else if (wait_cnt_q == WAIT_LAST) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        psel1_d     = 1'b0;
        psel2_d     = 1'b0;
        penable_d   = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of transfers against a two-slave memory model,
// plus hand-written reset-abort and stuck-slave sequences (timeout variant under APB_TIMEOUT_EN).
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  int errCount   = 0;
  int checkCount = 0;

  // Slave model state: wait states requested, stuck-low flag, ACCESS cycle counter, memory.
  int         waitReq = 0;
  logic       stuck   = 1'b0;
  int         accCnt  = 0;
  logic [7:0] mem [0:255];
  logic       readySel;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       expSel2;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs [12];

  always #5 PCLK = ~PCLK;

  apb_master dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA1   (PRDATA1),
    .PRDATA2   (PRDATA2),
    .PREADY1   (PREADY1),
    .PREADY2   (PREADY2)
  );

  // The unselected slave always shows the opposite ready and 0xFF data so a wrong mux is visible.
  assign readySel = !stuck && (accCnt >= waitReq);
  assign PREADY1  = PSEL1 ? readySel : !readySel;
  assign PREADY2  = PSEL2 ? readySel : !readySel;
  assign PRDATA1  = PSEL1 ? mem[PADDR] : 8'hFF;
  assign PRDATA2  = PSEL2 ? mem[PADDR] : 8'hFF;

  always @(posedge PCLK) begin
    if ((PSEL1 || PSEL2) && PENABLE && !readySel) accCnt <= accCnt + 1;
    else accCnt <= 0;
    if (!PRESETn) begin
      mem[8'h82] <= 8'h4A;
      mem[8'h03] <= 8'hFF;
    end else if ((PSEL1 || PSEL2) && PENABLE && readySel && PWRITE) begin
      mem[PADDR] <= PWDATA;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts and ends on a falling edge; the DUT is expected to be idle on entry.
  task automatic applyStimulus(input vec_t v, input int idx);
    int   accCycles;
    logic done;
    checkOutput($sformatf("v%0d idle cmd_ready", idx), cmd_ready, 1);
    waitReq   = v.waits;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(negedge PCLK);
    // Busy: keep offering a different command that must be ignored.
    cmd_write = ~v.wr;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    checkOutput($sformatf("v%0d setup sel/en/ready/rsp", idx),
                {PSEL1, PSEL2, PENABLE, cmd_ready, rsp_valid},
                {~v.expSel2, v.expSel2, 1'b0, 1'b0, 1'b0});
    checkOutput($sformatf("v%0d setup pwrite/paddr/pwdata", idx),
                {PWRITE, PADDR, PWDATA}, {v.wr, v.addr, v.wdata});
    accCycles = 0;
    done      = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge PCLK);
      if (rsp_valid) done = 1'b1;
      else begin
        accCycles++;
        checkOutput($sformatf("v%0d access bus cyc%0d", idx, accCycles),
                    {PSEL1, PSEL2, PENABLE, PWRITE, cmd_ready, PADDR, PWDATA},
                    {~v.expSel2, v.expSel2, 1'b1, v.wr, 1'b0, v.addr, v.wdata});
      end
    end
    checkOutput($sformatf("v%0d response seen", idx), done, 1);
    checkOutput($sformatf("v%0d access cycles", idx), accCycles, v.waits + 1);
    checkOutput($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.expRdata);
    checkOutput($sformatf("v%0d idle bus after rsp", idx),
                {PSEL1, PSEL2, PENABLE, cmd_ready, rsp_err}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cycles;
    logic sawRsp;

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;

    vecs[0]  = '{1'b1, 8'h01, 8'hAA, 0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h82, 8'h00, 0, 1'b1, 8'h4A};
    vecs[2]  = '{1'b0, 8'h03, 8'h00, 3, 1'b0, 8'hFF};
    vecs[3]  = '{1'b1, 8'h02, 8'h4A, 0, 1'b0, 8'hFF};
    vecs[4]  = '{1'b1, 8'h03, 8'hFF, 1, 1'b0, 8'hFF};
    vecs[5]  = '{1'b1, 8'h04, 8'h33, 2, 1'b0, 8'hFF};
    vecs[6]  = '{1'b0, 8'h01, 8'h00, 0, 1'b0, 8'hAA};
    vecs[7]  = '{1'b0, 8'h02, 8'h00, 0, 1'b0, 8'h4A};
    vecs[8]  = '{1'b0, 8'h03, 8'h00, 0, 1'b0, 8'hFF};
    vecs[9]  = '{1'b0, 8'h04, 8'h00, 1, 1'b0, 8'h33};
    vecs[10] = '{1'b1, 8'h85, 8'h5C, 2, 1'b1, 8'h33};
    vecs[11] = '{1'b0, 8'h85, 8'h00, 0, 1'b1, 8'h5C};

    repeat (3) @(negedge PCLK);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset bus", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    checkOutput("reset rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);
    @(negedge PCLK);
    checkOutput("single rsp pulse after last vector", rsp_valid, 0);

    // Reset while a transfer sits in ACCESS: bus drops, no response is produced.
    stuck     = 1'b1;
    waitReq   = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h10;
    cmd_wdata = 8'h77;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    checkOutput("rst-abort in access", {PSEL1, PENABLE}, 2'b11);
    @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    checkOutput("rst-abort bus dropped", {PSEL1, PSEL2, PENABLE, cmd_ready, rsp_valid},
                {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    checkOutput("rst-abort paddr/rdata cleared", {PADDR, rsp_rdata}, 0);
    PRESETn = 1'b1;
    stuck   = 1'b0;
    @(negedge PCLK);
    checkOutput("rst-abort no rsp after release", {rsp_valid, cmd_ready}, 2'b01);
    applyStimulus('{1'b0, 8'h82, 8'h00, 0, 1'b1, 8'h4A}, 12);

    // Slave1 never becomes ready.
    stuck     = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h05;
    cmd_wdata = 8'h00;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    sawRsp    = 1'b0;
`ifdef APB_TIMEOUT_EN
    cycles = 0;
    for (int k = 0; k < 100 && !sawRsp; k++) begin
      @(negedge PCLK);
      if (rsp_valid) sawRsp = 1'b1;
      else cycles++;
    end
    checkOutput("timeout rsp seen", sawRsp, 1);
    checkOutput("timeout access cycles", cycles, 16);
    checkOutput("timeout rsp_err", rsp_err, 1);
    checkOutput("timeout rdata unchanged", rsp_rdata, 8'h4A);
    checkOutput("timeout back to idle", {PSEL1, PENABLE, cmd_ready}, 3'b001);
    @(negedge PCLK);
    checkOutput("timeout err one cycle", {rsp_valid, rsp_err}, 2'b00);
    stuck = 1'b0;
`else
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (rsp_valid) sawRsp = 1'b1;
      if (PSEL1 && PENABLE && !cmd_ready) cycles++;
    end
    checkOutput("stuck no rsp", sawRsp, 0);
    checkOutput("stuck access cycles", cycles, 100);
    checkOutput("stuck rsp_err tied low", rsp_err, 0);
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    stuck   = 1'b0;
    @(negedge PCLK);
`endif
    applyStimulus('{1'b0, 8'h82, 8'h00, 1, 1'b1, 8'h4A}, 13);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
